// File: rtl/seg_bar_pkg.sv
// Shared constants for the seven-segment bar reader: segment codes, segment
// indices, FSM state type and a 4-bit successor helper.
package seg_bar_pkg;

  // Segment codes in {g,f,e,d,c,b,a} order
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam int IDX_A = 0;
  localparam int IDX_B = 1;
  localparam int IDX_C = 2;
  localparam int IDX_D = 3;
  localparam int IDX_E = 4;
  localparam int IDX_F = 5;
  localparam int IDX_G = 6;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_DONE   = 1'b1
  } rd_state_e;

  function automatic logic [3:0] inc4(input logic [3:0] v);
    return v + 4'd1;
  endfunction

endpackage

// File: rtl/seg_bar_reader_if.sv
// Seven-segment bar bus: seven 24-bit colour buses from the controller plus
// the reader's recovered digit and status pulses.
interface seg_bar_if #(
  parameter int CNT_W = 8
);
  logic [23:0]      bar_0;
  logic [23:0]      bar_1;
  logic [23:0]      bar_2;
  logic [23:0]      bar_3;
  logic [23:0]      bar_4;
  logic [23:0]      bar_5;
  logic [23:0]      bar_6;
  logic [3:0]       digit;
  logic             digit_valid;
  logic             bad_pattern;
  logic             seq_error;
  logic [CNT_W-1:0] accept_count;

  modport master (
    output bar_0, bar_1, bar_2, bar_3, bar_4, bar_5, bar_6,
    input  digit, digit_valid, bad_pattern, seq_error, accept_count
  );

  modport slave (
    input  bar_0, bar_1, bar_2, bar_3, bar_4, bar_5, bar_6,
    output digit, digit_valid, bad_pattern, seq_error, accept_count
  );
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational seven-segment pattern to hex value decoder; valid is low for
// any pattern outside the sixteen digit glyphs (including blank).
module seg7_pattern_decode
  import seg_bar_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] value_o,
  output logic       valid_o
);

  always_comb begin
    value_o = 4'h0;
    valid_o = 1'b1;
    case (seg_i)
      SEG_0:   value_o = 4'h0;
      SEG_1:   value_o = 4'h1;
      SEG_2:   value_o = 4'h2;
      SEG_3:   value_o = 4'h3;
      SEG_4:   value_o = 4'h4;
      SEG_5:   value_o = 4'h5;
      SEG_6:   value_o = 4'h6;
      SEG_7:   value_o = 4'h7;
      SEG_8:   value_o = 4'h8;
      SEG_9:   value_o = 4'h9;
      SEG_A:   value_o = 4'hA;
      SEG_B:   value_o = 4'hB;
      SEG_C:   value_o = 4'hC;
      SEG_D:   value_o = 4'hD;
      SEG_E:   value_o = 4'hE;
      SEG_F:   value_o = 4'hF;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_bar_reader.sv
// Recovers hex digits from seven segment colour buses: debounces the lit
// pattern, decodes it once per stable run and checks digits count up mod 16.
module seg_bar_reader
  import seg_bar_pkg::*;
#(
  parameter int          STABLE_CYCLES = 3,
  parameter logic [23:0] ON_MASK       = 24'hFFFFFF,
  parameter int          CNT_W         = 8
) (
  input  logic     clk,
  input  logic     rst,
  seg_bar_if.slave bus
);

  localparam int             SC_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STABLE_CYCLES);
  localparam logic [SC_W-1:0] SC_HIT = SC_W'(STABLE_CYCLES - 1);

  logic [23:0] bar_arr [7];
  logic [6:0]  seg_now;

  assign bar_arr[IDX_A] = bus.bar_0;
  assign bar_arr[IDX_B] = bus.bar_1;
  assign bar_arr[IDX_C] = bus.bar_2;
  assign bar_arr[IDX_D] = bus.bar_3;
  assign bar_arr[IDX_E] = bus.bar_4;
  assign bar_arr[IDX_F] = bus.bar_5;
  assign bar_arr[IDX_G] = bus.bar_6;

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_lit
      assign seg_now[gi] = |(bar_arr[gi] & ON_MASK);
    end
  endgenerate

  logic [3:0] dec_value;
  logic       dec_valid;

  seg7_pattern_decode u_decode (
    .seg_i   (seg_now),
    .value_o (dec_value),
    .valid_o (dec_valid)
  );

  rd_state_e        state_q, state_d;
  logic [6:0]       seg_q;
  logic [SC_W-1:0]  stab_q, stab_d;
  logic [6:0]       last_acc_q, last_acc_d;
  logic             have_prev_q, have_prev_d;
  logic [3:0]       digit_q, digit_d;
  logic             valid_q, valid_d;
  logic             bad_q, bad_d;
  logic             seq_q, seq_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic changed;
  logic eligible;
  logic repeat_p;
  logic accept;

  always_comb begin
    changed  = (seg_now != seg_q);
    repeat_p = (seg_now == last_acc_q);

    if (changed)               stab_d = '0;
    else if (stab_q == SC_MAX) stab_d = stab_q;
    else                       stab_d = stab_q + SC_W'(1);

    // A change while DONE reopens the run on the same edge, so a
    // single-cycle stability window still gets its acceptance.
    eligible = (state_q == ST_SETTLE) || changed;
    accept   = eligible && (stab_d == SC_HIT) && !repeat_p;

    state_d = state_q;
    if (eligible) state_d = (accept || repeat_p) ? ST_DONE : ST_SETTLE;

    last_acc_d  = last_acc_q;
    have_prev_d = have_prev_q;
    digit_d     = digit_q;
    valid_d     = 1'b0;
    bad_d       = 1'b0;
    seq_d       = 1'b0;
    count_d     = count_q;

    if (accept) begin
      last_acc_d = seg_now;
      if (seg_now == SEG_BLANK) begin
        // blank only clears last_acc so the same digit can be re-accepted
      end else if (dec_valid) begin
        digit_d     = dec_value;
        valid_d     = 1'b1;
        seq_d       = have_prev_q && (dec_value != inc4(digit_q));
        count_d     = count_q + CNT_W'(1);
        have_prev_d = 1'b1;
      end else begin
        bad_d       = 1'b1;
        have_prev_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_SETTLE;
      seg_q       <= SEG_BLANK;
      stab_q      <= '0;
      last_acc_q  <= SEG_BLANK;
      have_prev_q <= 1'b0;
      digit_q     <= 4'h0;
      valid_q     <= 1'b0;
      bad_q       <= 1'b0;
      seq_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_now;
      stab_q      <= stab_d;
      last_acc_q  <= last_acc_d;
      have_prev_q <= have_prev_d;
      digit_q     <= digit_d;
      valid_q     <= valid_d;
      bad_q       <= bad_d;
      seq_q       <= seq_d;
      count_q     <= count_d;
    end
  end

  assign bus.digit        = digit_q;
  assign bus.digit_valid  = valid_q;
  assign bus.bad_pattern  = bad_q;
  assign bus.seq_error    = seq_q;
  assign bus.accept_count = count_q;

endmodule

// File: tb/tb_seg_bar_reader.sv
// Directed bench for seg_bar_reader with STABLE_CYCLES=3: each task drives a
// scenario of held patterns and checks pulses, digit and count inline.
module tb_seg_bar_reader;

  localparam logic [23:0] LIT = 24'hFF0000;

  logic clk;
  logic rst;

  seg_bar_if #(.CNT_W(8)) bus ();

  seg_bar_reader #(
    .STABLE_CYCLES (3),
    .ON_MASK       (24'hFFFFFF),
    .CNT_W         (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int         nv;
  int         nb;
  int         ns;
  int         pulse_edge;
  logic [3:0] pulse_digit;
  logic       pulse_seq;
  int         exp_count;

  task automatic set_pat(input logic [6:0] p);
    bus.bar_0 = p[0] ? LIT : 24'h0;
    bus.bar_1 = p[1] ? LIT : 24'h0;
    bus.bar_2 = p[2] ? LIT : 24'h0;
    bus.bar_3 = p[3] ? LIT : 24'h0;
    bus.bar_4 = p[4] ? LIT : 24'h0;
    bus.bar_5 = p[5] ? LIT : 24'h0;
    bus.bar_6 = p[6] ? LIT : 24'h0;
  endtask

  // Drive pattern p for n rising edges, tallying pulses seen after each edge
  task automatic hold(input logic [6:0] p, input int n);
    set_pat(p);
    nv = 0; nb = 0; ns = 0; pulse_edge = 0; pulse_digit = 4'h0; pulse_seq = 1'b0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (bus.digit_valid === 1'b1) begin
        nv++; pulse_edge = i; pulse_digit = bus.digit; pulse_seq = bus.seq_error;
      end
      if (bus.bad_pattern === 1'b1) nb++;
      if (bus.seq_error === 1'b1) ns++;
    end
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once
  task automatic async_reset(input string tag);
    #3 rst = 1'b0;
    #1;
    checks++; if (bus.digit !== 4'h0) begin errors++; $display("FAIL %s_digit: got %h want 0", tag, bus.digit); end
    checks++; if (bus.accept_count !== 8'd0) begin errors++; $display("FAIL %s_count: got %0d want 0", tag, bus.accept_count); end
    checks++; if ({bus.digit_valid, bus.bad_pattern, bus.seq_error} !== 3'b000) begin
      errors++; $display("FAIL %s_pulses: got %b want 000", tag, {bus.digit_valid, bus.bad_pattern, bus.seq_error});
    end
    #2 rst = 1'b1;
    exp_count = 0;
  endtask

  task automatic check_accept(input string tag, input logic [3:0] d, input logic s);
    exp_count++;
    checks++; if (nv !== 1) begin errors++; $display("FAIL %s_nv: got %0d want 1", tag, nv); end
    checks++; if (pulse_edge !== 3) begin errors++; $display("FAIL %s_edge: got %0d want 3", tag, pulse_edge); end
    checks++; if (pulse_digit !== d) begin errors++; $display("FAIL %s_digit: got %h want %h", tag, pulse_digit, d); end
    checks++; if (pulse_seq !== s || ns !== int'(s)) begin
      errors++; $display("FAIL %s_seq: got %b (n=%0d) want %b", tag, pulse_seq, ns, s);
    end
    checks++; if (bus.accept_count !== 8'(exp_count)) begin
      errors++; $display("FAIL %s_count: got %0d want %0d", tag, bus.accept_count, exp_count);
    end
    $display("accept %-10s digit=%h seq_error=%b count=%0d", tag, pulse_digit, pulse_seq, bus.accept_count);
  endtask

  task automatic check_quiet(input string tag);
    checks++; if (nv !== 0 || nb !== 0 || ns !== 0) begin
      errors++; $display("FAIL %s_quiet: got valid=%0d bad=%0d seq=%0d want 0 0 0", tag, nv, nb, ns);
    end
    $display("quiet  %-10s valid=%0d bad=%0d seq=%0d", tag, nv, nb, ns);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_pat(7'h00);
    exp_count = 0;
    @(posedge clk); #1;
    async_reset("reset");
    hold(7'h00, 5);
    check_quiet("blank_rel");
  endtask

  task automatic test_single();
    hold(7'h06, 6);
    check_accept("single", 4'h1, 1'b0);
  endtask

  task automatic test_count_up();
    logic [6:0] pats [4];
    pats[0] = 7'h3F; pats[1] = 7'h06; pats[2] = 7'h5B; pats[3] = 7'h4F;
    @(posedge clk); #1;
    async_reset("cnt_rst");
    for (int k = 0; k < 4; k++) begin
      hold(pats[k], 4);
      check_accept($sformatf("up%0d", k), 4'(k), 1'b0);
    end
    hold(7'h71, 4);
    check_accept("to_F", 4'hF, 1'b1);
    hold(7'h3F, 4);
    check_accept("wrap", 4'h0, 1'b0);
  endtask

  task automatic test_seq_error();
    hold(7'h06, 4);
    check_accept("seq1", 4'h1, 1'b0);
    hold(7'h4F, 4);
    check_accept("seq_jump", 4'h3, 1'b1);
  endtask

  task automatic test_glitch();
    hold(7'h5B, 4);
    check_accept("gl_2", 4'h2, 1'b1);
    hold(7'h7F, 2);
    check_quiet("glitch");
    hold(7'h5B, 4);
    check_quiet("same_back");
    hold(7'h7F, 4);
    check_accept("gl_8", 4'h8, 1'b1);
  endtask

  task automatic test_bad();
    hold(7'h49, 4);
    checks++; if (nb !== 1 || nv !== 0) begin errors++; $display("FAIL bad_pulse: got bad=%0d valid=%0d want 1 0", nb, nv); end
    checks++; if (bus.digit !== 4'h8) begin errors++; $display("FAIL bad_digit_hold: got %h want 8", bus.digit); end
    checks++; if (bus.accept_count !== 8'(exp_count)) begin
      errors++; $display("FAIL bad_count_hold: got %0d want %0d", bus.accept_count, exp_count);
    end
    $display("bad    49         bad=%0d digit=%h", nb, bus.digit);
    hold(7'h4F, 4);
    check_accept("after_bad", 4'h3, 1'b0);
    hold(7'h66, 2);
    check_quiet("pre_rst");
    async_reset("mid_rst");
    hold(7'h66, 4);
    check_accept("post_rst", 4'h4, 1'b0);
  endtask

  task automatic test_blank();
    hold(7'h00, 4);
    check_quiet("blank");
    hold(7'h66, 4);
    check_accept("reaccept", 4'h4, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_count_up();
    test_seq_error();
    test_glitch();
    test_bad();
    test_blank();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
